// File: rtl/accumulator_unit.sv
// Bus-side accumulator: single-cycle LOAD/ADD/SUB/AND/OR/XOR and bit-serial shifts.
// Optional saturating ADD/SUB is enabled by defining ACC_SAT_EN.
module accumulator_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [WIDTH-1:0]   Bus_in,
  input  logic [2:0]         OP,
  input  logic [SHAMT_W-1:0] SHAMT,
  input  logic               WE,
  input  logic               OE,
  output logic [WIDTH-1:0]   Acc_out,
  output logic               BUSY,
  output logic               DONE,
  output logic               ZF,
  output logic               CF,
  output logic               NF
);
  localparam logic [2:0] OP_LOAD = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
                         OP_OR   = 3'd4, OP_XOR = 3'd5, OP_SHL = 3'd6, OP_SHR = 3'd7;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_acc, w_acc_nxt, r_acc_out, w_acc_out_nxt;
  logic [SHAMT_W-1:0]   r_cnt, w_cnt_nxt;
  logic                 r_dir, w_dir_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_zf, w_zf_nxt, r_cf, w_cf_nxt, r_nf, w_nf_nxt;
  logic                 w_acc_wr;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_diff;
  logic                 w_borrow;

  assign w_sum    = {1'b0, r_acc} + {1'b0, Bus_in};
  assign w_diff   = r_acc - Bus_in;
  assign w_borrow = Bus_in > r_acc;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_acc_out <= '0;
      r_cnt     <= '0;
      r_dir     <= 1'b0;
      r_done    <= 1'b0;
      r_zf      <= 1'b0;
      r_cf      <= 1'b0;
      r_nf      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_acc_out <= w_acc_out_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dir     <= w_dir_nxt;
      r_done    <= w_done_nxt;
      r_zf      <= w_zf_nxt;
      r_cf      <= w_cf_nxt;
      r_nf      <= w_nf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_cf_nxt    = r_cf;
    w_done_nxt  = 1'b0;
    w_acc_wr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (WE) begin
          w_done_nxt = 1'b1;
          w_acc_wr   = 1'b1;
          w_cf_nxt   = 1'b0;
          case (OP)
            OP_LOAD: w_acc_nxt = Bus_in;
            OP_ADD: begin
              w_cf_nxt = w_sum[WIDTH];
`ifdef ACC_SAT_EN
              w_acc_nxt = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
              w_acc_nxt = w_sum[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
              w_cf_nxt = w_borrow;
`ifdef ACC_SAT_EN
              w_acc_nxt = w_borrow ? '0 : w_diff;
`else
              w_acc_nxt = w_diff;
`endif
            end
            OP_AND: w_acc_nxt = r_acc & Bus_in;
            OP_OR:  w_acc_nxt = r_acc | Bus_in;
            OP_XOR: w_acc_nxt = r_acc ^ Bus_in;
            default: begin
              // Shifts: a zero count completes at once without touching Acc.
              w_acc_wr = 1'b0;
              if (SHAMT != '0) begin
                w_done_nxt  = 1'b0;
                w_cnt_nxt   = SHAMT;
                w_dir_nxt   = (OP == OP_SHR);
                w_state_nxt = S_SHIFT;
              end
            end
          endcase
        end
      end
      default: begin
        w_acc_wr  = 1'b1;
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_dir) begin
          w_acc_nxt = {1'b0, r_acc[WIDTH-1:1]};
          w_cf_nxt  = r_acc[0];
        end else begin
          w_acc_nxt = {r_acc[WIDTH-2:0], 1'b0};
          w_cf_nxt  = r_acc[WIDTH-1];
        end
        if (r_cnt == SHAMT_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
    endcase
    w_zf_nxt = w_acc_wr ? (w_acc_nxt == '0)     : r_zf;
    w_nf_nxt = w_acc_wr ? w_acc_nxt[WIDTH-1]    : r_nf;
    // Bus drive shows pre-edge Acc, frozen while a shift is running.
    w_acc_out_nxt = !OE ? '0 : ((r_state == S_SHIFT) ? r_acc_out : r_acc);
  end

  assign Acc_out = r_acc_out;
  assign BUSY    = (r_state == S_SHIFT);
  assign DONE    = r_done;
  assign ZF      = r_zf;
  assign CF      = r_cf;
  assign NF      = r_nf;
endmodule

// File: tb/tb_accumulator_unit.sv
// Directed self-checking bench for accumulator_unit (WIDTH=8, SHAMT_W=3).
module tb_accumulator_unit;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] Bus_in = '0;
  logic [2:0] OP = '0;
  logic [2:0] SHAMT = '0;
  logic       WE = 1'b0, OE = 1'b0;
  logic [7:0] Acc_out;
  logic       BUSY, DONE, ZF, CF, NF;
  int n_pass = 0, n_total = 0;

  accumulator_unit #(.WIDTH(8), .SHAMT_W(3)) dut (
    .CLK(CLK), .RESET(RESET), .Bus_in(Bus_in), .OP(OP), .SHAMT(SHAMT),
    .WE(WE), .OE(OE), .Acc_out(Acc_out), .BUSY(BUSY), .DONE(DONE),
    .ZF(ZF), .CF(CF), .NF(NF));

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // Issue one WE cycle; outputs are sampled 1 time unit after the edge.
  task automatic issue(input logic [2:0] op, input logic [7:0] bus, input logic [2:0] sh);
    OP = op; Bus_in = bus; SHAMT = sh; WE = 1'b1;
    step();
    WE = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; #2;
    n_total++;
    if ({Acc_out, BUSY, DONE, ZF, CF, NF} !== 13'h0)
      $display("FAIL reset_init: got acc=%h b=%b d=%b z=%b c=%b n=%b want all 0", Acc_out, BUSY, DONE, ZF, CF, NF);
    else n_pass++;
    @(negedge CLK); RESET = 1'b0;
    // Mid-run pulse: load a negative value with OE, then reset asynchronously.
    OE = 1'b1;
    issue(3'd0, 8'h80, 3'd0);
    step();
    n_total++;
    if (Acc_out !== 8'h80 || NF !== 1'b1) $display("FAIL reset_pre: acc=%h nf=%b want 80/1", Acc_out, NF);
    else n_pass++;
    #2 RESET = 1'b1; #1;
    n_total++;
    if ({Acc_out, BUSY, DONE, ZF, CF, NF} !== 13'h0)
      $display("FAIL reset_mid: got acc=%h b=%b d=%b z=%b c=%b n=%b want all 0", Acc_out, BUSY, DONE, ZF, CF, NF);
    else n_pass++;
    @(negedge CLK); RESET = 1'b0; OE = 1'b0;
  endtask

  task automatic test_load();
    issue(3'd0, 8'h5A, 3'd0);
    n_total++;
    if (DONE !== 1'b1 || Acc_out !== 8'h00) $display("FAIL load_done: done=%b acc_out=%h want 1/00", DONE, Acc_out);
    else n_pass++;
    OE = 1'b1; step();
    n_total++;
    if (Acc_out !== 8'h5A || DONE !== 1'b0 || {ZF, CF, NF} !== 3'b000)
      $display("FAIL load_oe: acc_out=%h done=%b zcn=%b want 5a/0/000", Acc_out, DONE, {ZF, CF, NF});
    else n_pass++;
    OE = 1'b0; step();
    n_total++;
    if (Acc_out !== 8'h00) $display("FAIL load_oe_off: acc_out=%h want 00", Acc_out);
    else n_pass++;
    OE = 1'b1;
  endtask

  task automatic test_add();
    logic [7:0] exp_acc;
`ifdef ACC_SAT_EN
    exp_acc = 8'hFF;
`else
    exp_acc = 8'h1A;
`endif
    issue(3'd1, 8'hC0, 3'd0);
    n_total++;
    if (Acc_out !== 8'h5A || DONE !== 1'b1 || CF !== 1'b1)
      $display("FAIL add_edge: acc_out=%h done=%b cf=%b want 5a/1/1", Acc_out, DONE, CF);
    else n_pass++;
    step();
    n_total++;
    if (Acc_out !== exp_acc || NF !== exp_acc[7] || ZF !== 1'b0)
      $display("FAIL add_result: acc=%h nf=%b zf=%b want %h/%b/0", Acc_out, NF, ZF, exp_acc, exp_acc[7]);
    else n_pass++;
  endtask

  task automatic test_sub();
    logic [7:0] exp_acc;
    issue(3'd0, 8'h1A, 3'd0);
    issue(3'd2, 8'h1B, 3'd0);
    step();
`ifdef ACC_SAT_EN
    exp_acc = 8'h00;
`else
    exp_acc = 8'hFF;
`endif
    n_total++;
    if (Acc_out !== exp_acc || CF !== 1'b1 || NF !== exp_acc[7] || ZF !== (exp_acc == 8'h00))
      $display("FAIL sub_borrow: acc=%h c=%b n=%b z=%b want %h/1/%b/%b", Acc_out, CF, NF, ZF, exp_acc, exp_acc[7], exp_acc == 8'h00);
    else n_pass++;
  endtask

  task automatic test_logic();
    issue(3'd0, 8'hF0, 3'd0);
    n_total++;
    if (CF !== 1'b0 || NF !== 1'b1) $display("FAIL load_clr_cf: cf=%b nf=%b want 0/1", CF, NF);
    else n_pass++;
    issue(3'd3, 8'h3C, 3'd0);
    issue(3'd4, 8'h0F, 3'd0);
    step();
    n_total++;
    if (Acc_out !== 8'h3F) $display("FAIL and_or: acc=%h want 3f", Acc_out);
    else n_pass++;
    issue(3'd5, 8'hBF, 3'd0);
    step();
    n_total++;
    if (Acc_out !== 8'h80 || NF !== 1'b1 || ZF !== 1'b0) $display("FAIL xor: acc=%h n=%b z=%b want 80/1/0", Acc_out, NF, ZF);
    else n_pass++;
    issue(3'd5, 8'h80, 3'd0);
    n_total++;
    if (ZF !== 1'b1 || NF !== 1'b0 || CF !== 1'b0) $display("FAIL xor_zero: z=%b n=%b c=%b want 1/0/0", ZF, NF, CF);
    else n_pass++;
  endtask

  task automatic test_shift();
    int busy_cycles = 0;
    int done_edge = 0;
    issue(3'd0, 8'h81, 3'd0);
    issue(3'd6, 8'h00, 3'd3);
    n_total++;
    if (BUSY !== 1'b1 || DONE !== 1'b0 || Acc_out !== 8'h81)
      $display("FAIL shl_start: busy=%b done=%b acc_out=%h want 1/0/81", BUSY, DONE, Acc_out);
    else n_pass++;
    busy_cycles = 1;
    // A LOAD issued while busy must be dropped.
    issue(3'd0, 8'h00, 3'd0);
    for (int e = 2; e <= 8 && done_edge == 0; e++) begin
      if (BUSY) busy_cycles++;
      if (DONE) done_edge = e;
      if (done_edge == 0) step();
    end
    n_total++;
    if (done_edge !== 4 || busy_cycles !== 3)
      $display("FAIL shl_timing: done_edge=%0d busy_cycles=%0d want 4/3", done_edge, busy_cycles);
    else n_pass++;
    n_total++;
    if (Acc_out !== 8'h81 || CF !== 1'b0) $display("FAIL shl_hold: acc_out=%h cf=%b want 81/0", Acc_out, CF);
    else n_pass++;
    step();
    n_total++;
    if (Acc_out !== 8'h08 || DONE !== 1'b0 || {ZF, NF} !== 2'b00)
      $display("FAIL shl_result: acc=%h done=%b zn=%b want 08/0/00", Acc_out, DONE, {ZF, NF});
    else n_pass++;
    // Single-step right shift: counter boundary of one.
    issue(3'd0, 8'h81, 3'd0);
    issue(3'd7, 8'h00, 3'd1);
    step();
    n_total++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || CF !== 1'b1) $display("FAIL shr1: done=%b busy=%b cf=%b want 1/0/1", DONE, BUSY, CF);
    else n_pass++;
    issue(3'd6, 8'h00, 3'd0);
    n_total++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || CF !== 1'b0) $display("FAIL shamt0: done=%b busy=%b cf=%b want 1/0/0", DONE, BUSY, CF);
    else n_pass++;
    step();
    n_total++;
    if (Acc_out !== 8'h40) $display("FAIL shamt0_acc: acc=%h want 40", Acc_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    int done_seen = 0;
    issue(3'd0, 8'hF0, 3'd0);
    issue(3'd7, 8'h00, 3'd7);
    step(); step();
    n_total++;
    if (BUSY !== 1'b1 || CF !== 1'b0 || NF !== 1'b0) $display("FAIL shr_mid: busy=%b cf=%b nf=%b want 1/0/0", BUSY, CF, NF);
    else n_pass++;
    #2 RESET = 1'b1; #1;
    n_total++;
    if ({Acc_out, BUSY, DONE, ZF, CF, NF} !== 13'h0)
      $display("FAIL shr_reset: acc=%h b=%b d=%b z=%b c=%b n=%b want all 0", Acc_out, BUSY, DONE, ZF, CF, NF);
    else n_pass++;
    @(negedge CLK); RESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (DONE || BUSY) done_seen++;
    end
    n_total++;
    if (done_seen !== 0 || Acc_out !== 8'h00) $display("FAIL shr_abort: done/busy cycles=%0d acc=%h want 0/00", done_seen, Acc_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
